// File: rtl/switch_mcu_lsu.sv
// Load/store unit: turns one decoded load/store request from execute into a
// single AHB-Lite transfer, returns extended load data with a write-back
// strobe, stalls the core while busy and reports misaligned / bus error /
// timeout faults on the completion pulse.
//
// Handshake: the core pulses in_req for one cycle; it is only sampled while
// the unit is IDLE (out_busy=0). Completion is a one-cycle out_done pulse
// with out_fault valid in the same cycle. The bus side follows AHB-Lite:
// an address phase holds until in_hready=1, the data phase completes on
// in_hready=1, and in_hresp=1 together with in_hready=1 ends an error.
module switch_mcu_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_CNT_W       = 9
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_req,
  input  logic        in_we,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        out_busy,
  output logic        out_done,
  output logic        out_rd_we,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rdata,
  output logic [1:0]  out_fault,
  output logic [31:0] out_haddr,
  output logic        out_hwrite,
  output logic [2:0]  out_hsize,
  output logic [2:0]  out_hburst,
  output logic [1:0]  out_htrans,
  output logic        out_hmastlock,
  output logic [31:0] out_hwdata,
  input  logic        in_hready,
  input  logic        in_hresp,
  input  logic [31:0] in_hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] FAULT_OK    = 2'd0;
  localparam logic [1:0] FAULT_ALIGN = 2'd1;
  localparam logic [1:0] FAULT_BUS   = 2'd2;
  localparam logic [1:0] FAULT_TMO   = 2'd3;

  localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Request fields latched at acceptance.
  logic [31:0]         r_addr;
  logic [1:0]          r_size;
  logic                r_we;
  logic                r_uns;
  logic [31:0]         r_wdata;
  logic [4:0]          r_rd;
  logic [TO_CNT_W-1:0] r_to_cnt;

  // Output registers.
  logic                r_busy;
  logic                r_done;
  logic                r_rd_we;
  logic [31:0]         r_rdata;
  logic [1:0]          r_fault;
  logic [31:0]         r_haddr;
  logic                r_hwrite;
  logic [2:0]          r_hsize;
  logic [1:0]          r_htrans;
  logic [31:0]         r_hwdata;

  // Combinational helpers.
  logic                w_cap;
  logic                w_mis;
  logic [31:0]         w_addr;
  logic [1:0]          w_size;
  logic                w_we;
  logic                w_uns;
  logic [31:0]         w_wdata;
  logic [4:0]          w_rd;
  logic [31:0]         w_wrep;
  logic                w_to_hit;
  logic [1:0]          w_fault;
  logic                w_load_ok;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;

  assign out_busy      = r_busy;
  assign out_done      = r_done;
  assign out_rd_we     = r_rd_we;
  assign out_rd        = r_rd;
  assign out_rdata     = r_rdata;
  assign out_fault     = r_fault;
  assign out_haddr     = r_haddr;
  assign out_hwrite    = r_hwrite;
  assign out_hsize     = r_hsize;
  assign out_hburst    = 3'b000;
  assign out_htrans    = r_htrans;
  assign out_hmastlock = 1'b0;
  assign out_hwdata    = r_hwdata;

  // Request capture view: live inputs on acceptance, latched copy otherwise.
  always_comb begin
    w_cap   = (r_state == ST_IDLE) && in_req;
    w_addr  = w_cap ? in_addr     : r_addr;
    w_size  = w_cap ? in_size     : r_size;
    w_we    = w_cap ? in_we       : r_we;
    w_uns   = w_cap ? in_unsigned : r_uns;
    w_rd    = w_cap ? in_rd       : r_rd;
    w_mis   = (in_size == 2'd3) ||
              ((in_size == 2'd1) && in_addr[0]) ||
              ((in_size == 2'd2) && (in_addr[1:0] != 2'b00));
    case (in_size)
      2'd0:    w_wrep = {4{in_wdata[7:0]}};
      2'd1:    w_wrep = {2{in_wdata[15:0]}};
      default: w_wrep = in_wdata;
    endcase
    w_wdata = w_cap ? w_wrep : r_wdata;
  end

  // Little-endian lane extraction and sign/zero extension of load data.
  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: w_byte = in_hrdata[7:0];
      2'd1: w_byte = in_hrdata[15:8];
      2'd2: w_byte = in_hrdata[23:16];
      2'd3: w_byte = in_hrdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = r_addr[1] ? in_hrdata[31:16] : in_hrdata[15:0];
    case (r_size)
      2'd0:    w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = in_hrdata;
    endcase
  end

  // Next-state logic, completion fault code and load write-back qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_fault     = FAULT_OK;
    w_load_ok   = 1'b0;
    w_to_hit    = TO_EN && !in_hready && (r_to_cnt == TO_LAST);
    case (r_state)
      ST_IDLE: begin
        if (in_req) begin
          if (w_mis) begin
            w_state_nxt = ST_FIN;
            w_fault     = FAULT_ALIGN;
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (w_to_hit) begin
          w_state_nxt = ST_FIN;
          w_fault     = FAULT_TMO;
        end else if (in_hready) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_to_hit) begin
          w_state_nxt = ST_FIN;
          w_fault     = FAULT_TMO;
        end else if (in_hready) begin
          w_state_nxt = ST_FIN;
          w_fault     = in_hresp ? FAULT_BUS : FAULT_OK;
          w_load_ok   = !in_hresp && !r_we;
        end
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait-state counter: counts consecutive stalled bus cycles, clears on ready.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_to_cnt <= '0;
    end else if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && !in_hready) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Request latches and registered outputs derived from the next state.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_addr   <= '0;
      r_size   <= '0;
      r_we     <= 1'b0;
      r_uns    <= 1'b0;
      r_wdata  <= '0;
      r_rd     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_we  <= 1'b0;
      r_rdata  <= '0;
      r_fault  <= FAULT_OK;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= '0;
      r_htrans <= HTRANS_IDLE;
      r_hwdata <= '0;
    end else begin
      r_addr   <= w_addr;
      r_size   <= w_size;
      r_we     <= w_we;
      r_uns    <= w_uns;
      r_wdata  <= w_wdata;
      r_rd     <= w_rd;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (w_state_nxt == ST_FIN);
      r_fault  <= w_fault;
      r_rd_we  <= w_load_ok && (r_rd != 5'd0);
      if (w_load_ok) begin
        r_rdata <= w_load;
      end
      if (w_state_nxt == ST_ADDR) begin
        r_haddr  <= w_addr;
        r_hwrite <= w_we;
        r_hsize  <= {1'b0, w_size};
        r_htrans <= HTRANS_NONSEQ;
      end else begin
        r_haddr  <= '0;
        r_hwrite <= 1'b0;
        r_hsize  <= '0;
        r_htrans <= HTRANS_IDLE;
      end
      r_hwdata <= (w_state_nxt == ST_DATA) ? w_wdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_switch_mcu_lsu.sv
// Directed and randomized bench for switch_mcu_lsu. The bench plays the AHB
// slave, predicts every cycle of each transfer from the access parameters,
// and checks outputs mid-cycle (negedge) against a behavioural model.
module tb_switch_mcu_lsu;

  localparam int TO = 8;

  logic        clk;
  logic        in_rst;
  logic        in_req;
  logic        in_we;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        out_busy;
  logic        out_done;
  logic        out_rd_we;
  logic [4:0]  out_rd;
  logic [31:0] out_rdata;
  logic [1:0]  out_fault;
  logic [31:0] out_haddr;
  logic        out_hwrite;
  logic [2:0]  out_hsize;
  logic [2:0]  out_hburst;
  logic [1:0]  out_htrans;
  logic        out_hmastlock;
  logic [31:0] out_hwdata;
  logic        in_hready;
  logic        in_hresp;
  logic [31:0] in_hrdata;

  int checks;
  int errors;

  switch_mcu_lsu #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(4)) dut (
    .in_clk(clk), .in_rst(in_rst), .in_req(in_req), .in_we(in_we),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_rd(in_rd), .out_busy(out_busy),
    .out_done(out_done), .out_rd_we(out_rd_we), .out_rd(out_rd),
    .out_rdata(out_rdata), .out_fault(out_fault), .out_haddr(out_haddr),
    .out_hwrite(out_hwrite), .out_hsize(out_hsize), .out_hburst(out_hburst),
    .out_htrans(out_htrans), .out_hmastlock(out_hmastlock),
    .out_hwdata(out_hwdata), .in_hready(in_hready), .in_hresp(in_hresp),
    .in_hrdata(in_hrdata)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: alignment rule from the access size in bytes.
  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    int unsigned nbytes;
    nbytes = 1 << size;
    return (size == 2'd3) || ((addr % nbytes) != 0);
  endfunction

  // Reference model: little-endian lane shift, mask, then extend.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] hrdata);
    int unsigned nbits;
    int unsigned off;
    logic [63:0] v;
    logic [63:0] mask;
    nbits = 8 << size;
    off   = addr % 4;
    v     = {32'h0, hrdata} >> (8 * off);
    if (nbits < 32) begin
      mask = (64'd1 << nbits) - 64'd1;
      v    = v & mask;
      if (!uns && v[nbits-1]) v = v | ~mask;
    end
    return v[31:0];
  endfunction

  // Reference model: store data replicated across byte lanes.
  function automatic logic [31:0] model_wrep(input logic [1:0] size, input logic [31:0] wdata);
    if (size == 2'd0) return (wdata & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (wdata & 32'hFFFF) * 32'h00010001;
    return wdata;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(out_busy),   32'd0);
    check({tag, "_done"},   32'(out_done),   32'd0);
    check({tag, "_rd_we"},  32'(out_rd_we),  32'd0);
    check({tag, "_fault"},  32'(out_fault),  32'd0);
    check({tag, "_htrans"}, 32'(out_htrans), 32'd0);
    check({tag, "_haddr"},  out_haddr,       32'd0);
    check({tag, "_hwdata"}, out_hwdata,      32'd0);
    check({tag, "_rdata"},  out_rdata,       32'd0);
    check({tag, "_rd"},     32'(out_rd),     32'd0);
    check({tag, "_hburst"}, 32'(out_hburst), 32'd0);
    check({tag, "_lock"},   32'(out_hmastlock), 32'd0);
  endtask

  // Driver + per-cycle checker for one access. aw/dw are wait states in the
  // address/data phase; a value >= TO means the slave never becomes ready.
  task automatic run_access(input string tag, input logic we, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input int aw, input int dw,
                            input logic [31:0] hrdata, input logic err, input logic extra);
    logic       mis;
    int         a_end;
    int         d_end;
    int         fin;
    logic [1:0] exp_fault;
    logic       exp_we;
    mis = model_mis(size, addr);
    if (mis) begin
      a_end = 0; d_end = 0; fin = 1; exp_fault = 2'd1;
    end else if (aw >= TO) begin
      a_end = TO; d_end = TO; fin = TO + 1; exp_fault = 2'd3;
    end else if (dw >= TO) begin
      a_end = aw + 1; d_end = aw + 1 + TO; fin = d_end + 1; exp_fault = 2'd3;
    end else begin
      a_end = aw + 1; d_end = aw + 2 + dw; fin = d_end + 1;
      exp_fault = err ? 2'd2 : 2'd0;
    end
    exp_we = !we && (exp_fault == 2'd0) && (rd != 5'd0);

    @(negedge clk);
    in_req = 1'b1; in_we = we; in_size = size; in_unsigned = uns;
    in_addr = addr; in_wdata = wdata; in_rd = rd;
    in_hready = 1'($urandom_range(0, 1)); in_hresp = 1'b0; in_hrdata = $urandom;

    for (int c = 1; c <= fin + 1; c++) begin
      @(negedge clk);
      // Scramble request inputs after acceptance to prove they are latched.
      in_req = extra && (c == 1);
      in_we = 1'($urandom_range(0, 1)); in_size = 2'($urandom_range(0, 3));
      in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom_range(0, 31));
      in_unsigned = 1'($urandom_range(0, 1));
      if (c <= fin) begin
        check({tag, "_busy"}, 32'(out_busy), 32'd1);
        check({tag, "_done"}, 32'(out_done), 32'(c == fin));
        check({tag, "_htrans"}, 32'(out_htrans), (c <= a_end) ? 32'd2 : 32'd0);
        if (c <= a_end) begin
          check({tag, "_haddr"},  out_haddr,       addr);
          check({tag, "_hwrite"}, 32'(out_hwrite), 32'(we));
          check({tag, "_hsize"},  32'(out_hsize),  32'(size));
        end
        if (we && c > a_end && c <= d_end)
          check({tag, "_hwdata"}, out_hwdata, model_wrep(size, wdata));
        if (c == fin) begin
          check({tag, "_fault"}, 32'(out_fault), 32'(exp_fault));
          check({tag, "_rd_we"}, 32'(out_rd_we), 32'(exp_we));
          check({tag, "_rd"},    32'(out_rd),    32'(rd));
          if (exp_we) check({tag, "_rdata"}, out_rdata, model_load(size, uns, addr, hrdata));
        end else begin
          check({tag, "_fault0"}, 32'(out_fault), 32'd0);
          check({tag, "_rd_we0"}, 32'(out_rd_we), 32'd0);
        end
      end else begin
        check({tag, "_idle_busy"},   32'(out_busy),   32'd0);
        check({tag, "_idle_done"},   32'(out_done),   32'd0);
        check({tag, "_idle_htrans"}, 32'(out_htrans), 32'd0);
      end
      // Slave response for the cycle now in progress.
      in_hresp  = 1'b0;
      in_hrdata = $urandom;
      if (c <= a_end) begin
        in_hready = (aw < TO) && (c == a_end);
      end else if (c <= d_end) begin
        in_hready = (dw < TO) && (c == d_end);
        in_hresp  = err;
        in_hrdata = hrdata;
      end else begin
        in_hready = 1'($urandom_range(0, 1));
      end
    end
    in_req = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    in_rst = 1'b0; in_req = 1'b0; in_we = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = 32'h0; in_wdata = 32'h0; in_rd = 5'd0;
    in_hready = 1'b1; in_hresp = 1'b0; in_hrdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    in_rst = 1'b1;

    // Directed accesses
    run_access("lw",  1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
    run_access("lb",  1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80AA55CC, 1'b0, 1'b0);
    run_access("lbu", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80AA55CC, 1'b0, 1'b0);
    run_access("lh",  1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd8, 0, 0, 32'h80AA55CC, 1'b0, 1'b0);
    run_access("lw_x0", 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5'd0, 0, 0, 32'h11223344, 1'b0, 1'b0);
    run_access("sb",  1'b1, 2'd0, 1'b0, 32'h201, 32'h12345678, 5'd9, 2, 0, 32'h0, 1'b0, 1'b1);
    run_access("sh",  1'b1, 2'd1, 1'b0, 32'h202, 32'hCAFEF00D, 5'd1, 0, 1, 32'h0, 1'b0, 1'b0);
    run_access("mis_lw", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd3, 0, 0, 32'h0, 1'b0, 1'b1);
    run_access("mis_lh", 1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 5'd3, 0, 0, 32'h0, 1'b0, 1'b0);
    run_access("mis_s3", 1'b1, 2'd3, 1'b0, 32'h100, 32'h0, 5'd3, 0, 0, 32'h0, 1'b0, 1'b0);
    run_access("berr", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd4, 0, 1, 32'h55555555, 1'b1, 1'b0);
    run_access("tmo_a", 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd4, TO, 0, 32'h0, 1'b0, 1'b0);
    run_access("tmo_d", 1'b1, 2'd2, 1'b0, 32'h404, 32'hA5A5A5A5, 5'd4, 1, TO, 32'h0, 1'b0, 1'b0);
    run_access("nearto", 1'b0, 2'd1, 1'b1, 32'h406, 32'h0, 5'd2, TO - 1, TO - 1, 32'hBEEF1234, 1'b0, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      run_access("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset during the data phase
    @(negedge clk);
    in_req = 1'b1; in_we = 1'b0; in_size = 2'd2; in_addr = 32'h500; in_rd = 5'd10;
    in_hready = 1'b1; in_hresp = 1'b0;
    @(negedge clk);
    in_req = 1'b0; in_hready = 1'b1;
    @(negedge clk);
    check("rst_pre_busy", 32'(out_busy), 32'd1);
    in_hready = 1'b0;
    in_rst = 1'b0;
    #1;
    check_all_zero("rst_mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_hold_done", 32'(out_done), 32'd0);
      check("rst_hold_busy", 32'(out_busy), 32'd0);
    end
    in_rst = 1'b1;
    run_access("post_rst", 1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 5'd11, 0, 0, 32'h0BADF00D, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_mcu_lsu.md
Name: switch_mcu_lsu

Overview:
Load/store unit sitting directly downstream of the core's execute stage. It takes one decoded load/store request (address, size, sign, store data, rd) and runs a single AHB-Lite data-bus transfer. It returns sign/zero-extended load data with a register write-back strobe. It stalls the core while busy and reports misaligned accesses, bus errors and timeouts as faults.

Parameters:
TIMEOUT_CYCLES, 256, max consecutive in_hready=0 cycles in ADDR or DATA before abort; 0 disables the timeout.
TO_CNT_W, 9, timeout counter width; must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
in_clk  input  1  core clock
in_rst  input  1  asynchronous active-low reset
in_req  input  1  one-cycle request pulse from execute; sampled only in IDLE
in_we  input  1  1=store, 0=load
in_size  input  2  0=byte, 1=half, 2=word; 3 is illegal and treated as misaligned
in_unsigned  input  1  load zero-extends (lbu/lhu) when 1
in_addr  input  32  byte address from the ALU
in_wdata  input  32  store data (rs2)
in_rd  input  5  load destination register
out_busy  output  1  stall to core; high while state != IDLE
out_done  output  1  one-cycle completion pulse (loads, stores and faults)
out_rd_we  output  1  register write strobe; coincident with out_done for a successful load with rd != 0
out_rd  output  5  latched rd
out_rdata  output  32  extended load data; valid when out_rd_we=1
out_fault  output  2  valid with out_done: 0=ok, 1=misaligned, 2=bus error, 3=timeout
out_haddr  output  32  AHB address
out_hwrite  output  1  AHB write
out_hsize  output  3  AHB size, equal to in_size
out_hburst  output  3  constant 3'b000 (SINGLE)
out_htrans  output  2  IDLE=2'b00, NONSEQ=2'b10
out_hmastlock  output  1  constant 0
out_hwdata  output  32  AHB write data, driven in the data phase
in_hready  input  1  AHB ready
in_hresp  input  1  AHB error response
in_hrdata  input  32  AHB read data

Behaviour:
- Reset (in_rst=0, any time, including mid-transfer): state=IDLE; all outputs 0; htrans=IDLE; timeout counter 0. No completion pulse follows reset.
- States: IDLE, ADDR, DATA, FIN. All outputs are registered.
- IDLE with in_req=1:
  - Latch addr, size, we, unsigned, rd and lane-replicated wdata (sb: {4{wdata[7:0]}}; sh: {2{wdata[15:0]}}; sw: wdata).
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3): go to FIN with fault=1. No bus activity.
  - Otherwise go to ADDR.
- in_req is ignored in all states other than IDLE.
- ADDR: htrans=NONSEQ; haddr, hwrite and hsize are driven.
  - in_hready=1 at the clock edge: go to DATA and drive htrans=IDLE.
  - in_hready=0: hold ADDR with all address-phase signals stable.
- DATA: hwdata holds the latched store data. Wait for in_hready=1.
  - in_hready=1 and in_hresp=0: loads capture in_hrdata; go to FIN with fault=0.
  - in_hresp=1: go to FIN with fault=2 on the cycle in_hready=1 (completes the two-cycle error response). No write-back.
- Timeout: the counter increments on each cycle in ADDR or DATA with in_hready=0 and clears whenever in_hready=1. Reaching TIMEOUT_CYCLES forces htrans=IDLE and FIN with fault=3.
- FIN (one cycle):
  - out_done=1 and out_fault is valid.
  - out_rd_we=1 only for a load with fault=0 and rd!=0.
  - Then return to IDLE; out_busy drops the cycle after FIN.
  - out_done, out_rd_we and out_fault are 0 outside FIN.
- Load extraction (little-endian) uses latched addr[1:0]:
  - byte = hrdata[8*a+7 : 8*a];
  - half = hrdata[16*a[1]+15 : 16*a[1]];
  - sign-extend unless unsigned; word loads pass through.
- Latency with zero wait states: req edge T0 → ADDR in cycle 1 → DATA in cycle 2 → FIN/out_done in cycle 3. Each wait state adds one cycle. A misaligned access completes at cycle 1.
- out_busy=1 from cycle 1 through FIN inclusive.

Test Plan:
- lw addr=0x100, hrdata=0xDEADBEEF, zero waits → htrans=NONSEQ in cycle 1, out_done in cycle 3, rdata=0xDEADBEEF, rd_we=1, fault=0.
- lb addr=0x103, hrdata=0x80AA55CC → rdata=0xFFFFFF80; same access as lbu → 0x00000080; lh addr=0x102 → 0xFFFF80AA.
- sb addr=0x201, wdata=0x12345678, hready held low 2 cycles in ADDR → haddr/htrans stable; hwdata=0x78787878 in DATA; done at cycle 5; rd_we=0.
- lw addr=0x102 → no NONSEQ ever driven; done at cycle 1 with fault=1. A further in_req pulse while busy is ignored.
- Error response in DATA (hresp=1,hready=0 then hresp=1,hready=1) → fault=2, rd_we=0. Separately, hready stuck at 0 for TIMEOUT_CYCLES → fault=3, htrans=IDLE.
- in_rst asserted in DATA → all outputs 0 immediately, no out_done. After release, a new lw completes normally in 3 cycles.
